// File: rtl/tetris_pkg.sv
// Shared tetris grid definitions: cell codes, grid geometry, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tetris_pkg;

    localparam int GRID_COLS  = 12;
    localparam int GRID_ROWS  = 20;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;
    localparam int CELL_AW    = 8;
    localparam int CELL_DW    = 8;

    // Low nibble of a cell code; AIR is empty, BORDER marks the well walls/floor.
    typedef enum logic [3:0] {
        PC_AIR    = 4'd0,
        PC_I      = 4'd1,
        PC_J      = 4'd2,
        PC_L      = 4'd3,
        PC_O      = 4'd4,
        PC_S      = 4'd5,
        PC_T      = 4'd6,
        PC_Z      = 4'd7,
        PC_BORDER = 4'd8
    } piece_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/grid_init_walker.sv
// Walks every grid cell once in raster order, producing the empty-well pattern.
// Latency: one cell per clk while en is high; last flags the final cell combinationally.
// Backpressure: none; the walker advances unconditionally while enabled.
//
// Ports: clk, reset (async active-low), en (advance one cell per clk),
//        addr/wdata (cell being written this cycle), last (this is the final cell).
module grid_init_walker #(
    parameter int COLS   = 12,
    parameter int ROWS   = 20,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              last
);
    import tetris_pkg::*;

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Separate row/col counters keep the border decode free of any divider.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (en) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign addr  = addr_q;
    assign last  = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign wdata = (col_q == '0 || col_q == LAST_COL || row_q == LAST_ROW)
                 ? DATA_W'(PC_BORDER) : DATA_W'(PC_AIR);

endmodule

// File: rtl/grid_mem_arbiter.sv
// Time-division arbiter sharing the single-port grid RAM between video (even slots) and game logic.
// Latency: video data 2 clk after address sample; game gnt same cycle (<=1 clk wait), read data 1 clk after gnt.
// Backpressure: game side holds game_req until game_gnt; video is never stalled.
//
// Ports: clk, reset (async active-low); vid_active/vid_addr/vid_data (video read path);
//        game_req/we/addr/wdata/gnt/rvalid/rdata/err (game access); init_done;
//        mem_addr/we/wdata/rdata (grid RAM, 1-clk synchronous read).
// Build option: define GRID_INIT_EN to clear the grid and draw the well border after reset.
module grid_mem_arbiter #(
    parameter int GRID_COLS = tetris_pkg::GRID_COLS,
    parameter int GRID_ROWS = tetris_pkg::GRID_ROWS,
    parameter int ADDR_W    = tetris_pkg::CELL_AW,
    parameter int DATA_W    = tetris_pkg::CELL_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_active,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_err,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import tetris_pkg::*;

    localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

`ifdef GRID_INIT_EN
    localparam arb_state_e RESET_STATE = ST_INIT;
`else
    localparam arb_state_e RESET_STATE = ST_RUN;
`endif

    arb_state_e        state_q, state_d;
    logic              slot_q, slot_d;
    logic              vid_pend_q, vid_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
    logic              oob;

    assign oob = (game_addr > LAST_ADDR);

`ifdef GRID_INIT_EN
    logic [ADDR_W-1:0] walk_addr;
    logic [DATA_W-1:0] walk_wdata;
    logic              walk_last;

    grid_init_walker #(
        .COLS   (GRID_COLS),
        .ROWS   (GRID_ROWS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_walker (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ST_INIT),
        .addr  (walk_addr),
        .wdata (walk_wdata),
        .last  (walk_last)
    );
`endif

    always_comb begin
        state_d     = state_q;
        slot_d      = ~slot_q;
        vid_pend_d  = 1'b0;
        rd_pend_d   = 1'b0;
        rd_err_d    = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        game_gnt    = 1'b0;
        game_err    = 1'b0;
        init_done   = (state_q == ST_RUN);

        // RAM data arrives one cycle after the address, so it is latched one edge later.
        vid_data_d  = vid_pend_q ? mem_rdata : vid_data_q;

        // Read data is passed straight through on its rvalid cycle and held afterwards;
        // out-of-range reads return zero rather than whatever the RAM aliases to.
        game_rvalid = rd_pend_q;
        game_rdata  = rdata_hold_q;
        if (rd_pend_q) begin
            game_rdata = rd_err_q ? '0 : mem_rdata;
        end
        rdata_hold_d = game_rdata;

        // Gating on reset keeps every RAM-side strobe quiet while reset is held,
        // so a request held across reset cannot slip a write out early.
        if (reset) begin
            if (state_q == ST_INIT) begin
`ifdef GRID_INIT_EN
                mem_addr  = walk_addr;
                mem_we    = 1'b1;
                mem_wdata = walk_wdata;
                if (walk_last) begin
                    state_d = ST_RUN;
                end
`endif
            end else if (vid_active && !slot_q) begin
                mem_addr   = vid_addr;
                vid_pend_d = 1'b1;
            end else if (game_req) begin
                game_gnt = 1'b1;
                game_err = oob;
                mem_addr = game_addr;
                if (game_we) begin
                    mem_we = !oob;
                    if (!oob) begin
                        mem_wdata = game_wdata;
                    end
                end else begin
                    rd_pend_d = 1'b1;
                    rd_err_d  = oob;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RESET_STATE;
            slot_q       <= 1'b0;
            vid_pend_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_err_q     <= 1'b0;
            vid_data_q   <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            vid_pend_q   <= vid_pend_d;
            rd_pend_q    <= rd_pend_d;
            rd_err_q     <= rd_err_d;
            vid_data_q   <= vid_data_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign vid_data = vid_data_q;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter: stimulus pushes expected per-cycle behaviour,
// a negedge monitor pops and compares. Reference model is a plain array of cell values
// plus the slot/blanking arbitration rule.
module tb_grid_mem_arbiter;
    localparam int CELLS = 240;
`ifdef GRID_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk, reset, vid_active, game_req, game_we;
    logic [7:0] vid_addr, game_addr, game_wdata;
    logic [7:0] vid_data, game_rdata, mem_addr, mem_wdata;
    logic       game_gnt, game_rvalid, game_err, init_done, mem_we;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] ram [0:255] = '{default: 8'h00};

    grid_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .vid_active  (vid_active),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .game_err    (game_err),
        .init_done   (init_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        bit         gnt;
        bit         err;
        bit         we;
        bit         rvalid;
        bit         idone;
        bit         chk_addr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } rec_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } vid_t;

    rec_t       cyc_q[$];
    vid_t       vid_q[$];
    logic [7:0] rd_q[$];

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit [7:0]   model_mem [0:255];
    bit         m_slot, m_prev_rd, m_gnt;
    int         m_init_left;
    logic [7:0] exp_vid = 8'h00;
    rec_t       mon_r;
    vid_t       mon_v;
    logic [7:0] mon_d;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%02h expected=%02h", name, cyc, act, exp);
        end
    endtask

    // Empty well: border code on the side walls and the bottom row.
    function automatic logic [7:0] border(input int i);
        int c;
        int r;
        c = i % 12;
        r = i / 12;
        return (c == 0 || c == 11 || r == 19) ? 8'd8 : 8'd0;
    endfunction

    // Monitor: one expectation record per driven cycle.
    always @(negedge clk) begin
        if (!reset) exp_vid = 8'h00;
        if (cyc_q.size() > 0) begin
            mon_r = cyc_q.pop_front();
            check1("game_gnt", game_gnt, mon_r.gnt);
            check1("game_err", game_err, mon_r.err);
            check1("mem_we", mem_we, mon_r.we);
            check1("game_rvalid", game_rvalid, mon_r.rvalid);
            check1("init_done", init_done, mon_r.idone);
            if (mon_r.chk_addr) check8("mem_addr", mem_addr, mon_r.addr);
            if (mon_r.we) check8("mem_wdata", mem_wdata, mon_r.wdata);
            if (mon_r.rvalid && rd_q.size() > 0) begin
                mon_d = rd_q.pop_front();
                if (game_rvalid) check8("game_rdata", game_rdata, mon_d);
            end
            while (vid_q.size() > 0 && vid_q[0].due <= cyc) begin
                mon_v = vid_q.pop_front();
                exp_vid = mon_v.val;
            end
            check8("vid_data", vid_data, exp_vid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            m_slot = ~m_slot;
            if (m_init_left > 0) m_init_left--;
        end
    endtask

    // Apply inputs for the current cycle and record what the arbiter must do with them.
    task automatic drive(input bit vact, input bit req, input bit we,
                         input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] va);
        bit   run;
        bit   vslot;
        bit   oob;
        rec_t r;
        vid_t v;
        int   idx;
        vid_active = vact;
        game_req   = req;
        game_we    = we;
        game_addr  = addr;
        game_wdata = wd;
        vid_addr   = va;
        run   = (m_init_left == 0);
        vslot = run && vact && !m_slot;
        m_gnt = run && !vslot && req;
        oob   = (addr >= 8'd240);
        r.gnt = m_gnt;
        r.err = m_gnt && oob;
        r.rvalid = m_prev_rd;
        r.idone = run;
        r.chk_addr = 1'b0;
        r.we = 1'b0;
        r.addr = 8'h00;
        r.wdata = 8'h00;
        if (!run) begin
            idx = CELLS - m_init_left;
            r.we = 1'b1;
            r.chk_addr = 1'b1;
            r.addr = 8'(idx);
            r.wdata = border(idx);
        end else if (vslot) begin
            r.chk_addr = 1'b1;
            r.addr = va;
            v.due = cyc + 2;
            v.val = model_mem[va];
            vid_q.push_back(v);
        end else if (m_gnt) begin
            r.chk_addr = 1'b1;
            r.addr = addr;
            if (we) begin
                r.we = !oob;
                r.wdata = wd;
                if (!oob) model_mem[addr] = wd;
            end else begin
                rd_q.push_back(oob ? 8'h00 : model_mem[addr]);
            end
        end
        m_prev_rd = m_gnt && !we;
        cyc_q.push_back(r);
    endtask

    task automatic req_until_gnt(input bit vact, input bit we, input logic [7:0] addr,
                                 input logic [7:0] wd, input logic [7:0] va);
        for (int n = 0; n < 400; n++) begin
            drive(vact, 1'b1, we, addr, wd, va);
            tick();
            if (m_gnt) return;
        end
        failures++;
        $display("FAIL req_timeout addr=%02h got=no_grant expected=grant", addr);
    endtask

    task automatic check_reset_outputs();
        check1("rst_game_gnt", game_gnt, 1'b0);
        check1("rst_game_rvalid", game_rvalid, 1'b0);
        check1("rst_game_err", game_err, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check8("rst_mem_addr", mem_addr, 8'h00);
        check8("rst_mem_wdata", mem_wdata, 8'h00);
        check8("rst_vid_data", vid_data, 8'h00);
        check8("rst_game_rdata", game_rdata, 8'h00);
        check1("rst_init_done", init_done, !INIT_EN);
    endtask

    task automatic do_release();
        tick();
        reset = 1'b1;
        m_slot = 1'b0;
        m_prev_rd = 1'b0;
        m_init_left = INIT_EN ? CELLS : 0;
        if (INIT_EN) begin
            for (int i = 0; i < CELLS; i++) model_mem[i] = border(i);
        end
    endtask

    bit         r_vact, p_req, p_we;
    logic [7:0] p_addr, p_wd;

    initial begin
        reset = 1'b0;
        vid_active = 1'b1;
        vid_addr = 8'd3;
        game_req = 1'b1;
        game_we = 1'b1;
        game_addr = 8'd7;
        game_wdata = 8'h5A;
        m_slot = 1'b0;
        m_prev_rd = 1'b0;
        m_init_left = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        do_release();

        // Requests are held through INIT and must only be granted once RUN is reached.
        while (m_init_left > 0) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'd13, 8'h00, 8'($urandom_range(0, 239)));
            tick();
        end
        req_until_gnt(1'b0, 1'b0, 8'd13, 8'h00, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd11, 8'h00, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd228, 8'h00, 8'h00);

        // Blanking write then read back.
        req_until_gnt(1'b0, 1'b1, 8'd25, 8'h03, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd25, 8'h00, 8'h00);

        // Video slot beats a game request; game gets the following odd slot.
        while (m_slot) begin drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd25); tick(); end
        req_until_gnt(1'b1, 1'b0, 8'd11, 8'h00, 8'd25);
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd25); tick(); end

        // Out-of-range write and read.
        req_until_gnt(1'b0, 1'b1, 8'd240, 8'hFF, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd250, 8'h00, 8'h00);

        // vid_active drops on an even slot: that cycle belongs to the game.
        while (m_slot) begin drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd7); tick(); end
        req_until_gnt(1'b0, 1'b0, 8'd25, 8'h00, 8'h00);

        // Back-to-back blanking reads.
        for (int k = 0; k < 4; k++) req_until_gnt(1'b0, 1'b0, 8'(24 + k), 8'h00, 8'h00);

        // Randomised traffic with requests held until granted.
        r_vact = 1'b0;
        p_req = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) r_vact = ~r_vact;
            if (!p_req && $urandom_range(0, 3) != 0) begin
                p_req = 1'b1;
                p_we = 1'($urandom_range(0, 1));
                p_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                                     : 8'($urandom_range(0, 239));
                p_wd = 8'($urandom_range(0, 255));
            end
            drive(r_vact, p_req, p_we, p_addr, p_wd, 8'($urandom_range(0, 239)));
            if (m_gnt) p_req = 1'b0;
            tick();
        end

        // Reset one cycle after a read grant, with a write held during reset.
        req_until_gnt(1'b0, 1'b1, 8'd30, 8'h44, 8'h00);
        req_until_gnt(1'b0, 1'b0, 8'd30, 8'h00, 8'h00);
        reset = 1'b0;
        game_req = 1'b1;
        game_we = 1'b1;
        game_addr = 8'd30;
        game_wdata = 8'hEE;
        cyc_q.delete();
        rd_q.delete();
        vid_q.delete();
        m_prev_rd = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        tick();
        do_release();
        while (m_init_left > 0) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            tick();
        end
        req_until_gnt(1'b0, 1'b0, 8'd30, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick(); end

        checks++;
        if (rd_q.size() != 0 || cyc_q.size() != 0) begin
            failures++;
            $display("FAIL drain rd_left=%0d rec_left=%0d expected=0", rd_q.size(), cyc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
